// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with same-cycle write bypass, optional
// hard-wired zero register and a per-register busy scoreboard.
module regfile_2w2r #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_EN    = 1,
  parameter int ZERO_REG   = 31
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  wrEnA,
  input  logic [ADDR_WIDTH-1:0] wrAddrA,
  input  logic [DATA_WIDTH-1:0] wrDataA,
  input  logic                  wrEnB,
  input  logic [ADDR_WIDTH-1:0] wrAddrB,
  input  logic [DATA_WIDTH-1:0] wrDataB,
  input  logic                  rsvEn,
  input  logic [ADDR_WIDTH-1:0] rsvAddr,
  input  logic [ADDR_WIDTH-1:0] rdAddr1,
  input  logic [ADDR_WIDTH-1:0] rdAddr2,
  output logic [DATA_WIDTH-1:0] rdData1,
  output logic [DATA_WIDTH-1:0] rdData2,
  output logic                  rdReady1,
  output logic                  rdReady2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // A zero-register index outside the address space simply means no zero register.
  localparam bit ZERO_VALID = (ZERO_EN != 0) && (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
  logic                  rd_ready1_q, rd_ready1_d;
  logic                  rd_ready2_q, rd_ready2_d;
  logic                  wr_a_ok, wr_b_ok, rsv_ok;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] addr);
    return ZERO_VALID && (addr == ZERO_IDX);
  endfunction

  // Port B is checked first so it wins a same-address collision with port A.
  function automatic logic [DATA_WIDTH-1:0] bypass(input logic [ADDR_WIDTH-1:0] addr);
    if (is_zero(addr))                   return '0;
    else if (wrEnB && (wrAddrB == addr)) return wrDataB;
    else if (wrEnA && (wrAddrA == addr)) return wrDataA;
    else                                 return regs_q[addr];
  endfunction

  assign wr_a_ok = wrEnA && !is_zero(wrAddrA);
  assign wr_b_ok = wrEnB && !is_zero(wrAddrB);
  assign rsv_ok  = rsvEn && !is_zero(rsvAddr);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    busy_d = busy_q;
    if (wr_a_ok) begin
      regs_d[wrAddrA] = wrDataA;
      busy_d[wrAddrA] = 1'b0;
    end
    if (wr_b_ok) begin
      regs_d[wrAddrB] = wrDataB;
      busy_d[wrAddrB] = 1'b0;
    end
    // Reserve applied last: a producer issued this cycle outranks the retiring write.
    if (rsv_ok) busy_d[rsvAddr] = 1'b1;
  end

  always_comb begin
    rd_data1_d  = bypass(rdAddr1);
    rd_data2_d  = bypass(rdAddr2);
    rd_ready1_d = !busy_d[rdAddr1];
    rd_ready2_d = !busy_d[rdAddr2];
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q      <= '0;
      rd_data1_q  <= '0;
      rd_data2_q  <= '0;
      rd_ready1_q <= 1'b0;
      rd_ready2_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      busy_q      <= busy_d;
      rd_data1_q  <= rd_data1_d;
      rd_data2_q  <= rd_data2_d;
      rd_ready1_q <= rd_ready1_d;
      rd_ready2_q <= rd_ready2_d;
    end
  end

  assign rdData1  = rd_data1_q;
  assign rdData2  = rd_data2_q;
  assign rdReady1 = rd_ready1_q;
  assign rdReady2 = rd_ready2_q;

endmodule
